// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI receive path: byte width, receiver FSM
// state type, and the minimum SCLK half-period (in clk cycles) the
// synchronizer/edge-detect front end can resolve.
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_BITS      = 8;
  localparam int MIN_SCLK_HALF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rx_state_t;

endpackage : spi_pkg

// File: rtl/spi_rx_fifo.sv
// ---------------------------------------------------------------------------
// spi_rx_fifo
// First-word-fall-through synchronous FIFO for received SPI bytes.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   push        write push_data (accepted when not full, or when full and
//               a pop happens in the same cycle)
//   push_data   byte to store
//   pop         consume head entry (ignored when empty)
//   pop_data    head entry; 0 while empty
//   full/empty  occupancy flags
//   level       number of bytes held
// ---------------------------------------------------------------------------
module spi_rx_fifo import spi_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [SPI_BITS-1:0] push_data,
  input  logic                pop,
  output logic [SPI_BITS-1:0] pop_data,
  output logic                full,
  output logic                empty,
  output logic [LVL_W-1:0]    level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SPI_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    count;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign level   = count;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push into a full
  // FIFO is still accepted.
  assign do_push = push && (!full || do_pop);

  // Head entry is forced to 0 when empty so nothing stale leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by count,
  // so resetting it would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : spi_rx_fifo

// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
// SPI receive end (SCLK idles high, master shifts on falling edge, we sample
// on rising edge, MSB first, 8-bit bytes). Pins are synchronized into clk,
// bytes are deserialized and buffered in a FWFT FIFO with valid/ready output.
// SCLK high and low phases must each last at least MIN_SCLK_HALF clk cycles.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   CS           chip select from master, active low
//   SCLK         serial clock from master, idles high
//   SDO          serial data from master
//   m_data       head-of-FIFO byte
//   m_valid      FIFO non-empty
//   m_ready      consumer accepts m_data when m_valid && m_ready
//   frame_err    one-cycle pulse: CS released on a partial byte
//   overflow     sticky: byte dropped because FIFO full
//   clr_status   clears overflow
//   busy         synchronized CS is low
//   fifo_level   bytes currently held
// ---------------------------------------------------------------------------
module spi_slave_rx import spi_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                CS,
  input  logic                SCLK,
  input  logic                SDO,
  output logic [SPI_BITS-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                frame_err,
  output logic                overflow,
  input  logic                clr_status,
  output logic                busy,
  output logic [LVL_W-1:0]    fifo_level
);

  localparam int CNT_W = $clog2(SPI_BITS);

  // ---------------- synchronizers and edge detect ----------------
  logic [SYNC_STAGES-1:0] cs_ff, sclk_ff, sdo_ff;
  logic                   cs_prev, sclk_prev;
  logic                   cs_s, sclk_s, sdo_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  // NOTE: sequential state is always written with non-blocking assignments
  // so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_ff     <= '1;
      sclk_ff   <= '1;
      sdo_ff    <= '1;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      cs_ff     <= {cs_ff[SYNC_STAGES-2:0],   CS};
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], SCLK};
      sdo_ff    <= {sdo_ff[SYNC_STAGES-2:0],  SDO};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s      = cs_ff[SYNC_STAGES-1];
  assign sclk_s    = sclk_ff[SYNC_STAGES-1];
  assign sdo_s     = sdo_ff[SYNC_STAGES-1];
  assign sclk_rise = !sclk_prev && sclk_s;
  assign cs_fall   = cs_prev && !cs_s;
  assign cs_rise   = !cs_prev && cs_s;
  assign busy      = !cs_s;

  // ---------------- receive FSM ----------------
  rx_state_t           state, state_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [SPI_BITS-1:0] shift, shift_n;
  logic                frame_err_n;
  logic                push;
  logic [SPI_BITS-1:0] push_data;

  // The completed byte includes the bit being sampled on this edge.
  assign push_data = {shift[SPI_BITS-2:0], sdo_s};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    push        = 1'b0;
    frame_err_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_n = '0;
          state_n   = ACTIVE;
        end
      end
      ACTIVE: begin
        // Capture first, then look at CS: a byte completed on the same
        // cycle CS releases is delivered without error.
        if (sclk_rise) begin
          shift_n = push_data;
          if (bit_cnt == CNT_W'(SPI_BITS - 1)) begin
            push      = 1'b1;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end
        if (cs_rise) begin
          frame_err_n = (bit_cnt_n != '0);
          bit_cnt_n   = '0;
          shift_n     = '0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      frame_err <= frame_err_n;
    end
  end

  // ---------------- byte buffer ----------------
  logic fifo_full, fifo_empty;

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign m_valid = !fifo_empty;

  // A new drop wins over clr_status so an overflow in the clearing cycle
  // is never lost. Full implies non-empty, so m_ready alone means a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !m_ready) begin
      overflow <= 1'b1;
    end else if (clr_status) begin
      overflow <= 1'b0;
    end
  end

endmodule : spi_slave_rx
